// File: rtl/router_pkg.sv
// Shared definitions for the router port drain path.
// Holds the header field widths, the header field accessors, the drain FSM
// state encoding and the skid buffer entry layout.
package router_pkg;

    localparam int LEN_W  = 6;
    localparam int ADDR_W = 2;
    localparam int BYTE_W = 8;

    typedef enum logic [2:0] {
        IDLE,
        HDR,
        PAY,
        PAR,
        DONE
    } drain_state_e;

    typedef struct packed {
        logic              last;
        logic [BYTE_W-1:0] data;
    } skid_entry_t;

    // Header layout: {len[7:2], addr[1:0]}
    function automatic logic [LEN_W-1:0] hdr_len(input logic [BYTE_W-1:0] hdr);
        return hdr[BYTE_W-1:ADDR_W];
    endfunction

    function automatic logic [ADDR_W-1:0] hdr_addr(input logic [BYTE_W-1:0] hdr);
        return hdr[ADDR_W-1:0];
    endfunction

endpackage

// File: rtl/rx_skid_buf.sv
// Two-entry byte FIFO between the port FIFO reader and the downstream
// ready/valid interface. Each entry carries a data byte and its last marker.
// Ports:
//   clock, reset_n      clock, asynchronous active-low reset
//   flush               drop every stored entry (packet abort)
//   push, push_data,    write one entry; the caller guarantees space via count
//   push_last
//   m_valid, m_data,    output side, head entry of the FIFO
//   m_last, m_ready
//   count               current occupancy, 0..2
module rx_skid_buf
    import router_pkg::*;
(
    input  logic              clock,
    input  logic              reset_n,
    input  logic              flush,
    input  logic              push,
    input  logic [BYTE_W-1:0] push_data,
    input  logic              push_last,
    output logic              m_valid,
    output logic [BYTE_W-1:0] m_data,
    output logic              m_last,
    input  logic              m_ready,
    output logic [1:0]        count
);

    skid_entry_t mem [2];
    logic        rd_ptr;
    logic        wr_ptr;
    logic        pop;
    logic        do_push;

    assign m_valid = (count != 2'd0);
    assign m_data  = mem[rd_ptr].data;
    assign m_last  = mem[rd_ptr].last & m_valid;
    assign pop     = m_valid & m_ready;
    // A push into a full buffer is accepted only when the head leaves the same cycle.
    assign do_push = push & ((count != 2'd2) | pop);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            // NOTE: storage is reset here on purpose: m_data must read 0 while in
            // reset; larger RAMs would normally be left unreset.
            mem[0] <= '0;
            mem[1] <= '0;
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
        end else if (flush) begin
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= '{last: push_last, data: push_data};
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            unique case ({do_push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/router_port_drain.sv
// Downstream consumer for one router output port.
// Pops packets {hdr, payload[len], parity} from the port FIFO, forwards the
// header and payload as a ready/valid byte stream with a last marker, checks
// parity and address, and reports a one-cycle status pulse per packet.
// Ports:
//   clock, reset_n                 clock, asynchronous active-low reset
//   valid_out, data_out, read_enb  port FIFO read side (read latency 1)
//   m_valid, m_data, m_last,       forwarded byte stream
//   m_ready
//   sts_valid, sts_len,            per-packet status, fields valid with sts_valid
//   sts_par_err, sts_addr_err,
//   sts_abort
module router_port_drain
    import router_pkg::*;
#(
    parameter logic [ADDR_W-1:0] PORT_ID   = 2'd0,
    parameter int unsigned       STALL_MAX = 64
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              valid_out,
    input  logic [BYTE_W-1:0] data_out,
    output logic              read_enb,
    output logic              m_valid,
    output logic [BYTE_W-1:0] m_data,
    output logic              m_last,
    input  logic              m_ready,
    output logic              sts_valid,
    output logic [LEN_W-1:0]  sts_len,
    output logic              sts_par_err,
    output logic              sts_addr_err,
    output logic              sts_abort
);

    localparam int STALL_W = $clog2(STALL_MAX + 1);

    drain_state_e       state;
    drain_state_e       state_nxt;
    logic               in_flight;    // a read was issued last cycle; its byte is on data_out now
    logic [LEN_W-1:0]   req_cnt;      // reads issued in the current state
    logic [LEN_W-1:0]   land_cnt;     // payload bytes captured so far
    logic [LEN_W-1:0]   len_q;
    logic [BYTE_W-1:0]  acc;
    logic [STALL_W-1:0] stall_cnt;
    logic [1:0]         skid_count;
    logic               land;
    logic               in_body;
    logic               stall_hit;
    logic               credit_ok;
    logic               want_rd;
    logic               pay_last;
    logic               skid_push;
    logic               skid_push_last;

    assign land      = in_flight;
    assign in_body   = (state == PAY) || (state == PAR);
    // A landing byte wins over the timeout: it proves the FIFO is still delivering.
    assign stall_hit = in_body && !land && (stall_cnt == STALL_W'(STALL_MAX));
    // Forwarded bytes need a skid slot reserved at issue time, so in-flight reads count.
    assign credit_ok = (skid_count + {1'b0, in_flight}) < 2'd2;
    // Compare before increment so len=63 terminates without the 6-bit counter wrapping.
    assign pay_last  = (land_cnt == len_q - LEN_W'(1));

    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        want_rd = 1'b0;
        unique case (state)
            HDR:     want_rd = (req_cnt == '0) && credit_ok;
            PAY:     want_rd = (req_cnt < len_q) && credit_ok;
            PAR:     want_rd = (req_cnt == '0);
            default: want_rd = 1'b0;
        endcase
    end

    assign read_enb  = valid_out && want_rd && !stall_hit;
    assign sts_valid = (state == DONE);

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (valid_out) state_nxt = HDR;
            HDR:  if (land) state_nxt = (hdr_len(data_out) == '0) ? PAR : PAY;
            PAY: begin
                if (stall_hit)             state_nxt = DONE;
                else if (land && pay_last) state_nxt = PAR;
            end
            PAR:  if (stall_hit || land) state_nxt = DONE;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            in_flight <= 1'b0;
            req_cnt   <= '0;
            land_cnt  <= '0;
            len_q     <= '0;
            acc       <= '0;
            stall_cnt <= '0;
        end else begin
            state     <= state_nxt;
            in_flight <= read_enb;

            if (state_nxt != state) req_cnt <= '0;
            else if (read_enb)      req_cnt <= req_cnt + LEN_W'(1);

            if (state != PAY) land_cnt <= '0;
            else if (land)    land_cnt <= land_cnt + LEN_W'(1);

            if (!in_body || land)
                stall_cnt <= '0;
            else if (!valid_out && stall_cnt != STALL_W'(STALL_MAX))
                stall_cnt <= stall_cnt + STALL_W'(1);

            if (land && state == HDR) begin
                len_q <= hdr_len(data_out);
                acc   <= data_out;
            end else if (land && state == PAY) begin
                acc   <= acc ^ data_out;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sts_len      <= '0;
            sts_addr_err <= 1'b0;
            sts_par_err  <= 1'b0;
            sts_abort    <= 1'b0;
        end else if (land && state == HDR) begin
            sts_len      <= hdr_len(data_out);
            sts_addr_err <= (hdr_addr(data_out) != PORT_ID);
            sts_par_err  <= 1'b0;
            sts_abort    <= 1'b0;
        end else if (land && state == PAR) begin
            sts_par_err  <= (acc != data_out);
        end else if (stall_hit) begin
            sts_par_err  <= 1'b1;
            sts_abort    <= 1'b1;
        end
    end

    // Header and payload go downstream; the parity byte only feeds the checker.
    assign skid_push      = land && ((state == HDR) || (state == PAY));
    assign skid_push_last = (state == HDR) ? (hdr_len(data_out) == '0) : pay_last;

    rx_skid_buf u_skid (
        .clock     (clock),
        .reset_n   (reset_n),
        .flush     (stall_hit),
        .push      (skid_push),
        .push_data (data_out),
        .push_last (skid_push_last),
        .m_valid   (m_valid),
        .m_data    (m_data),
        .m_last    (m_last),
        .m_ready   (m_ready),
        .count     (skid_count)
    );

endmodule

// File: tb/tb_router_port_drain.sv
// Self-checking bench for router_port_drain: a port FIFO model feeds the DUT,
// expected output bytes and status words are queued when a packet is sent and
// compared as the DUT produces them.
module tb_router_port_drain;
    import router_pkg::*;

    localparam int STALL_MAX = 64;

    typedef struct packed {
        logic [7:0] data;
        logic       last;
    } out_t;

    typedef struct packed {
        logic [5:0] len;
        logic       par_err;
        logic       addr_err;
        logic       abort;
    } sts_t;

    logic       clock = 1'b0;
    logic       reset_n;
    logic       valid_out;
    logic [7:0] data_out;
    logic       read_enb;
    logic       m_valid;
    logic [7:0] m_data;
    logic       m_last;
    logic       m_ready;
    logic       sts_valid;
    logic [5:0] sts_len;
    logic       sts_par_err;
    logic       sts_addr_err;
    logic       sts_abort;

    out_t       exp_q [$];
    sts_t       sts_q [$];
    logic [7:0] port_q [$];
    logic [7:0] pay_q [$];
    int         n_checks = 0;
    int         n_bad = 0;
    int         out_cnt = 0;

    router_port_drain #(.PORT_ID(2'd0), .STALL_MAX(STALL_MAX)) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .valid_out    (valid_out),
        .data_out     (data_out),
        .read_enb     (read_enb),
        .m_valid      (m_valid),
        .m_data       (m_data),
        .m_last       (m_last),
        .m_ready      (m_ready),
        .sts_valid    (sts_valid),
        .sts_len      (sts_len),
        .sts_par_err  (sts_par_err),
        .sts_addr_err (sts_addr_err),
        .sts_abort    (sts_abort)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%0h exp=0x%0h @%0t", tag, got, exp, $time);
        end
    endtask

    // Port FIFO model: read_enb sampled mid-cycle, data presented just after the edge.
    initial begin : feeder
        bit rd;
        valid_out = 1'b0;
        data_out  = 8'h00;
        forever begin
            @(negedge clock);
            rd = read_enb;
            @(posedge clock);
            #1;
            if (rd && reset_n && port_q.size() != 0) data_out = port_q.pop_front();
            valid_out = (port_q.size() != 0);
        end
    end

    // Output and status monitor with scoreboard.
    always @(negedge clock) begin : monitor
        out_t       e;
        sts_t       s;
        logic       prev_stall;
        logic [7:0] prev_data;
        if (!reset_n) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("hold_valid", m_valid, 1);
                check("hold_data", m_data, prev_data);
            end
            prev_stall = m_valid && !m_ready;
            prev_data  = m_data;
            if (m_valid && m_ready) begin
                out_cnt++;
                if (exp_q.size() == 0) begin
                    check("out_extra", exp_q.size(), 1);
                end else begin
                    e = exp_q.pop_front();
                    check("out_data", m_data, e.data);
                    check("out_last", m_last, e.last);
                end
            end
            if (sts_valid) begin
                if (sts_q.size() == 0) begin
                    check("sts_extra", sts_q.size(), 1);
                end else begin
                    s = sts_q.pop_front();
                    check("sts_len", sts_len, s.len);
                    check("sts_par_err", sts_par_err, s.par_err);
                    check("sts_addr_err", sts_addr_err, s.addr_err);
                    check("sts_abort", sts_abort, s.abort);
                end
            end
        end
    end

    // Queues one packet into the port FIFO and its expectations into the
    // scoreboard. Only n_deliver payload bytes are fed; fewer than len means
    // the stream starves and must end in an abort.
    task automatic send_pkt(input logic [7:0] hdr, input bit corrupt, input int n_deliver);
        logic [7:0] par;
        int         len;
        bit         trunc;
        len   = int'(hdr[7:2]);
        trunc = (n_deliver < len);
        par   = hdr;
        port_q.push_back(hdr);
        exp_q.push_back('{data: hdr, last: (len == 0)});
        for (int i = 0; i < len; i++) begin
            par = par ^ pay_q[i];
            if (i < n_deliver) begin
                port_q.push_back(pay_q[i]);
                exp_q.push_back('{data: pay_q[i], last: (i == len - 1)});
            end
        end
        if (!trunc) port_q.push_back(corrupt ? 8'h00 : par);
        sts_q.push_back('{len: hdr[7:2], par_err: (corrupt || trunc),
                          addr_err: (hdr[1:0] != 2'd0), abort: trunc});
    endtask

    task automatic wait_drain(input int max_cycles);
        for (int i = 0; i < max_cycles; i++) begin
            if (exp_q.size() == 0 && sts_q.size() == 0) break;
            @(negedge clock);
        end
        check("drain", exp_q.size() + sts_q.size(), 0);
    endtask

    task automatic wait_out(input int target, input int max_cycles);
        for (int i = 0; i < max_cycles; i++) begin
            if (out_cnt >= target) break;
            @(negedge clock);
        end
        check("wait_out", (out_cnt >= target), 1);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_read_enb"}, read_enb, 0);
        check({tag, "_m_valid"}, m_valid, 0);
        check({tag, "_m_data"}, m_data, 0);
        check({tag, "_m_last"}, m_last, 0);
        check({tag, "_sts_valid"}, sts_valid, 0);
        check({tag, "_sts_len"}, sts_len, 0);
        check({tag, "_sts_par"}, sts_par_err, 0);
        check({tag, "_sts_addr"}, sts_addr_err, 0);
        check({tag, "_sts_abort"}, sts_abort, 0);
    endtask

    task automatic load_nominal();
        pay_q.delete();
        pay_q.push_back(8'h11);
        pay_q.push_back(8'h22);
        pay_q.push_back(8'h33);
    endtask

    initial begin : stim
        int base;
        reset_n = 1'b0;
        m_ready = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        check_zero("rst");
        reset_n = 1'b1;
        @(negedge clock);
        check("idle_rd", read_enb, 0);

        // Nominal packet and the same packet with a wrong parity byte.
        load_nominal();
        send_pkt(8'h0C, 1'b0, 3);
        wait_drain(200);
        send_pkt(8'h0C, 1'b1, 3);
        wait_drain(200);

        // Backpressure for 10 cycles in the middle of a len-20 payload.
        pay_q.delete();
        for (int i = 0; i < 20; i++) pay_q.push_back(8'(i * 7 + 1));
        base = out_cnt;
        send_pkt({6'd20, 2'b00}, 1'b0, 20);
        wait_out(base + 7, 200);
        @(posedge clock);
        #1;
        m_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            if (i >= 2) check("bp_rd_stop", read_enb, 0);
        end
        @(posedge clock);
        #1;
        m_ready = 1'b1;
        wait_drain(300);

        // Underflow after 2 of 5 payload bytes -> abort, then a clean packet.
        pay_q.delete();
        for (int i = 0; i < 5; i++) pay_q.push_back(8'(8'hA0 + i));
        send_pkt(8'h14, 1'b0, 2);
        wait_drain(STALL_MAX * 2 + 100);
        repeat (2) @(negedge clock);
        check("abort_idle", 32'(dut.state), 32'(IDLE));
        check("abort_rd", read_enb, 0);
        load_nominal();
        send_pkt(8'h0C, 1'b0, 3);
        wait_drain(200);

        // len=0 with the wrong address, then the longest packet.
        send_pkt(8'h01, 1'b0, 0);
        wait_drain(200);
        pay_q.delete();
        for (int i = 0; i < 63; i++) pay_q.push_back(8'($urandom_range(255)));
        base = out_cnt;
        send_pkt(8'hFC, 1'b0, 63);
        wait_drain(500);
        check("len63_count", out_cnt - base, 64);

        // Asynchronous reset in the middle of a payload.
        pay_q.delete();
        for (int i = 0; i < 10; i++) pay_q.push_back(8'(8'h50 + i));
        base = out_cnt;
        send_pkt(8'h28, 1'b0, 10);
        wait_out(base + 4, 200);
        #2;
        reset_n = 1'b0;
        #1;
        check_zero("mid_rst");
        port_q.delete();
        exp_q.delete();
        sts_q.delete();
        repeat (2) @(posedge clock);
        #1;
        reset_n = 1'b1;
        load_nominal();
        send_pkt(8'h0C, 1'b0, 3);
        wait_drain(200);

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
